// File: rtl/npu_requant_packer_if.sv
// Handshake bundle between the accumulator drain stream and the packed int8 write-back stream.
// The master modport is the side that drives beats in and accepts packed words.
interface npu_requant_packer_if #(
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8
);
   logic [ACC_WIDTH-1:0]   s_data;
   logic                   s_valid;
   logic                   s_ready;
   logic [4*OUT_WIDTH-1:0] m_data;
   logic                   m_valid;
   logic                   m_ready;
   logic                   m_last;

   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );

   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/npu_requant_packer.sv
// Requantises 32-bit accumulator beats to int8 (per-column bias, rounding shift, optional ReLU,
// saturation) and packs four lanes per output word for the write-back DMA.
module npu_requant_packer #(
   parameter int N         = 8,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic [4:0]                  cfg_shift,
   input  logic                        cfg_relu,
   input  logic                        bias_wr_en,
   input  logic [$clog2(N)-1:0]        bias_wr_idx,
   input  logic signed [ACC_WIDTH-1:0] bias_wr_data,
   npu_requant_packer_if.slave         bus,
   output logic                        busy,
   output logic [15:0]                 sat_count
);
   localparam int CW  = $clog2(N);
   localparam int T_W = ACC_WIDTH + 3;
   localparam logic signed [T_W-1:0] Q_MAX = T_W'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [T_W-1:0] Q_MIN = T_W'(-(2 ** (OUT_WIDTH - 1)));

   // Half-LSB of the post-shift result, so the arithmetic shift rounds half up.
   function automatic logic signed [T_W-1:0] round_add(input logic [4:0] sh);
      if (sh == 5'd0) return '0;
      return T_W'(1) << (sh - 5'd1);
   endfunction

   // Returns {clipped, lane}; ReLU takes precedence and never counts as a clip.
   function automatic logic [OUT_WIDTH:0] requant(input logic signed [T_W-1:0] r,
                                                  input logic relu);
      if (relu && r < 0) return '0;
      if (r > Q_MAX)     return {1'b1, Q_MAX[OUT_WIDTH-1:0]};
      if (r < Q_MIN)     return {1'b1, Q_MIN[OUT_WIDTH-1:0]};
      return {1'b0, r[OUT_WIDTH-1:0]};
   endfunction

   logic signed [ACC_WIDTH-1:0] bias_mem [N];
   logic [CW-1:0]               col;
   logic                        stall;
   logic                        accept;

   logic                        vld_p1;
   logic signed [T_W-1:0]       t1_p1;
   logic [4:0]                  shift_p1;
   logic                        relu_p1;
   logic [1:0]                  lane_p1;
   logic                        last_p1;

   logic signed [T_W-1:0]       r_p1;
   logic [OUT_WIDTH:0]          q_p1;
   logic                        fire_p1;
   logic                        word_wr;
   logic [3*OUT_WIDTH-1:0]      pack_p2;

   assign stall       = bus.m_valid && !bus.m_ready;
   assign bus.s_ready = !rst && !stall && !clear;
   assign accept      = bus.s_valid && bus.s_ready;

   assign r_p1    = t1_p1 >>> shift_p1;
   assign q_p1    = requant(r_p1, relu_p1);
   assign fire_p1 = vld_p1 && !stall && !clear;
   assign word_wr = fire_p1 && (lane_p1 == 2'd3);
   assign busy    = vld_p1 || bus.m_valid || (col != '0);

   // Stage 1 -> p1: bias add and rounding offset; stage 2 -> p2: lane pack
   always_ff @(posedge clk) begin
      if (accept) begin
         t1_p1    <= T_W'(signed'(bus.s_data)) + T_W'(bias_mem[col]) + round_add(cfg_shift);
         shift_p1 <= cfg_shift;
         relu_p1  <= cfg_relu;
         lane_p1  <= col[1:0];
         last_p1  <= (col == CW'(N - 1));
      end
      if (clear) begin
         pack_p2 <= '0;
      end else if (fire_p1) begin
         for (int k = 0; k < 3; k++) begin
            if (lane_p1 == 2'(k)) pack_p2[k*OUT_WIDTH +: OUT_WIDTH] <= q_p1[OUT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) bias_mem[i] <= '0;
         col         <= '0;
         vld_p1      <= 1'b0;
         bus.m_valid <= 1'b0;
         bus.m_data  <= '0;
         bus.m_last  <= 1'b0;
         sat_count   <= '0;
      end else begin
         if (bias_wr_en && ({1'b0, bias_wr_idx} < (CW + 1)'(N))) bias_mem[bias_wr_idx] <= bias_wr_data;
         if (clear) begin
            col         <= '0;
            vld_p1      <= 1'b0;
            bus.m_valid <= 1'b0;
            sat_count   <= '0;
         end else begin
            if (accept) col <= (col == CW'(N - 1)) ? '0 : col + 1'b1;
            if (!stall) vld_p1 <= accept;
            if (fire_p1 && q_p1[OUT_WIDTH] && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
            // A word written on the handshake edge replaces the one being accepted.
            if (word_wr) begin
               bus.m_valid <= 1'b1;
               bus.m_data  <= {q_p1[OUT_WIDTH-1:0], pack_p2};
               bus.m_last  <= last_p1;
            end else if (bus.m_valid && bus.m_ready) begin
               bus.m_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_npu_requant_packer.sv
// Randomised and directed bench for npu_requant_packer against an arithmetic reference model
// of bias/round/shift/ReLU/saturate and four-lane packing.
module tb_npu_requant_packer;
   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [4:0]  cfg_shift;
   logic        cfg_relu;
   logic        bias_wr_en;
   logic [2:0]  bias_wr_idx;
   logic [31:0] bias_wr_data;
   logic        busy;
   logic [15:0] sat_count;

   npu_requant_packer_if #(.ACC_WIDTH(32), .OUT_WIDTH(8)) bus ();

   npu_requant_packer #(.N(8), .ACC_WIDTH(32), .OUT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .bias_wr_en(bias_wr_en), .bias_wr_idx(bias_wr_idx), .bias_wr_data(bias_wr_data),
      .bus(bus), .busy(busy), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   longint      m_bias [8];
   int          mcol;
   int          msat;
   logic [7:0]  mlanes [4];
   logic [32:0] exp_q [$];
   logic [32:0] obs_q [$];
   logic [32:0] got_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Output collector and backpressure observer.
   always @(negedge clk) begin
      if (!rst && bus.m_valid && bus.m_ready) obs_q.push_back({bus.m_last, bus.m_data});
      if (!rst && bus.m_valid && !bus.m_ready) chk("s_ready_stall", {31'b0, bus.s_ready}, 32'd0);
   end

   function automatic logic [7:0] model_lane(input logic signed [31:0] acc, input longint b,
                                             input int sh, input bit relu, output bit sat);
      longint v;
      v = longint'(acc) + b;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      sat = 1'b0;
      if (relu && v < 0) v = 0;
      else if (v > 127) begin v = 127; sat = 1'b1; end
      else if (v < -128) begin v = -128; sat = 1'b1; end
      return v[7:0];
   endfunction

   task automatic model_accept(input logic [31:0] acc);
      bit s;
      mlanes[mcol % 4] = model_lane(acc, m_bias[mcol], int'(cfg_shift), cfg_relu, s);
      if (s && msat < 65535) msat++;
      if (mcol % 4 == 3) exp_q.push_back({(mcol == 7), mlanes[3], mlanes[2], mlanes[1], mlanes[0]});
      mcol = (mcol + 1) % 8;
   endtask

   task automatic model_reset();
      foreach (m_bias[i]) m_bias[i] = 0;
      mcol = 0;
      msat = 0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic send_beat(input logic [31:0] acc);
      int t = 0;
      bus.s_data  = acc;
      bus.s_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.s_ready) begin
            model_accept(acc);
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         t++;
         if (t > 300) begin
            chk("beat_timeout", 32'(t), 32'd0);
            bus.s_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic finish_row();
      while (mcol != 0) send_beat(32'd0);
   endtask

   task automatic set_bias(input int idx, input logic [31:0] val);
      bias_wr_en   = 1'b1;
      bias_wr_idx  = 3'(idx);
      bias_wr_data = val;
      @(posedge clk); #1;
      bias_wr_en   = 1'b0;
      m_bias[idx]  = longint'(signed'(val));
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 300) begin @(negedge clk); t++; end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic compare_out(input string tag);
      int n;
      chk({tag, "_nwords"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, obs_q[i][31:0], exp_q[i][31:0]);
         chk({tag, "_last"}, {31'b0, obs_q[i][32]}, {31'b0, exp_q[i][32]});
      end
      got_q = obs_q;
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [31:0] val);
      chk({tag, "_present"}, {31'b0, (got_q.size() > idx)}, 32'd1);
      if (got_q.size() > idx) chk(tag, got_q[idx][31:0], val);
   endtask

   function automatic logic [31:0] rand_acc();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'(int'($urandom_range(0, 20000)) - 10000);
   endfunction

   initial begin
      bit done;
      rst = 1'b1; clear = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
      bias_wr_en = 1'b0; bias_wr_idx = '0; bias_wr_data = '0;
      bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
      chk("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
      chk("rst_m_data", bus.m_data, 32'd0);
      chk("rst_m_last", {31'b0, bus.m_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_sat", {16'b0, sat_count}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Plain packing and two-cycle latency.
      for (int i = 1; i <= 4; i++) send_beat(32'(i));
      chk("lat_edge_t", {31'b0, bus.m_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_edge_t1", {31'b0, bus.m_valid}, 32'd1);
      for (int i = 5; i <= 8; i++) send_beat(32'(i));
      wait_idle();
      compare_out("basic");
      chk_word("basic_w0", 0, 32'h04030201);
      chk_word("basic_w1", 1, 32'h08070605);
      if (got_q.size() > 1) chk("basic_w1_last", {31'b0, got_q[1][32]}, 32'd1);
      chk("basic_sat", {16'b0, sat_count}, 32'd0);

      // Saturation with a per-beat shift change.
      cfg_shift = 5'd4; send_beat(32'h00001000);
      cfg_shift = 5'd0; send_beat(32'(-1000));
      send_beat(32'd0); send_beat(32'd0);
      finish_row();
      wait_idle();
      compare_out("sat");
      chk_word("sat_w0", 0, 32'h0000807F);
      chk("sat_count2", {16'b0, sat_count}, 32'd2);

      // Rounding and ReLU.
      cfg_shift = 5'd4; cfg_relu = 1'b0;
      send_beat(32'd24); send_beat(32'(-24));
      cfg_relu = 1'b1;
      send_beat(32'(-24)); send_beat(32'd0);
      cfg_relu = 1'b0;
      finish_row();
      wait_idle();
      compare_out("round");
      chk_word("round_w0", 0, 32'h0000FF02);
      chk("round_sat", {16'b0, sat_count}, 32'd2);

      // Bias table.
      for (int k = 0; k < 8; k++) set_bias(k, 32'(16 * k));
      cfg_shift = 5'd4;
      for (int i = 0; i < 8; i++) send_beat(32'd0);
      wait_idle();
      compare_out("bias");
      chk_word("bias_w0", 0, 32'h03020100);
      chk_word("bias_w1", 1, 32'h07060504);

      // Backpressure: 10 stalled cycles mid-row over four rows.
      cfg_shift = 5'd2;
      fork
         for (int i = 0; i < 32; i++) send_beat(rand_acc());
         begin
            repeat (5) @(posedge clk); #1;
            bus.m_ready = 1'b0;
            repeat (10) @(posedge clk); #1;
            bus.m_ready = 1'b1;
         end
      join
      wait_idle();
      compare_out("bp");
      chk("bp_sat", {16'b0, sat_count}, 32'(msat));

      // Mid-row clear drops the partial word.
      for (int i = 0; i < 3; i++) send_beat(rand_acc());
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      mcol = 0; msat = 0;
      chk("clr_sat", {16'b0, sat_count}, 32'd0);
      chk("clr_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) send_beat(rand_acc());
      wait_idle();
      compare_out("clr");

      // Randomised rounds with random downstream readiness.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 8; k++) set_bias(k, 32'(int'($urandom_range(0, 10000)) - 5000));
         cfg_shift = 5'($urandom_range(0, 12));
         cfg_relu  = 1'($urandom_range(0, 1));
         done = 1'b0;
         fork
            begin
               for (int i = 0; i < 16; i++) send_beat(rand_acc());
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk); #1;
                  bus.m_ready = ($urandom_range(0, 3) != 0);
               end
               bus.m_ready = 1'b1;
            end
         join
         wait_idle();
         compare_out("rand");
         chk("rand_sat", {16'b0, sat_count}, 32'(msat));
      end

      // Asynchronous reset mid-row while a word is held.
      cfg_shift = 5'd0; cfg_relu = 1'b0;
      set_bias(0, 32'd5);
      bus.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(32'h00010000);
      @(posedge clk); #1;
      chk("pre_rst_m_valid", {31'b0, bus.m_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
      chk("mid_rst_sat", {16'b0, sat_count}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
      model_reset();
      @(posedge clk); #3;
      rst = 1'b0;
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send_beat(32'd0);
      wait_idle();
      compare_out("post_rst");
      chk_word("post_rst_w0", 0, 32'h00000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
